// File: rtl/ysyx_23060236_btb_update.sv
// BTB update path: resolves EXU control-flow outcomes, raises IFU redirects on
// mispredicts and queues BTB training writes into a small FIFO that drains one
// entry per cycle into the BTB write port. Also keeps two performance counters.
module ysyx_23060236_btb_update #(
    parameter int ADDR_LEN   = 32,
    parameter int DATA_LEN   = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_LEN-1:0] in_pc,
    input  logic [DATA_LEN-1:0] in_pred_npc,
    input  logic [DATA_LEN-1:0] in_actual_npc,
    input  logic                in_taken,
    output logic                redirect_valid,
    output logic [DATA_LEN-1:0] redirect_pc,
    input  logic                redirect_ready,
    input  logic                wr_hold,
    output logic                btb_wvalid,
    output logic [ADDR_LEN-1:0] btb_awaddr,
    output logic [DATA_LEN-1:0] btb_wdata,
    output logic [31:0]         perf_cf_cnt,
    output logic [31:0]         perf_mis_cnt
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef struct packed {
        logic [ADDR_LEN-1:0] pc;
        logic [DATA_LEN-1:0] target;
    } wr_entry_t;

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t           state;
    logic [DATA_LEN-1:0] redirect_pc_q;

    wr_entry_t        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;

    logic             accept;
    logic             mis;
    logic             train;
    logic             push;
    logic             pop;

    logic [31:0]      cf_cnt;
    logic [31:0]      mis_cnt;

    // FIFO status from the wrap-extended pointers.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    // A full FIFO blocks input even if it pops this cycle: no bypass path.
    assign in_ready = (state == IDLE) && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign mis      = (in_pred_npc != in_actual_npc);
    assign train    = in_taken && mis;
    assign push     = accept && train;

    // The BTB write port has no backpressure, so every strobe is a pop.
    assign btb_wvalid = !fifo_empty && !wr_hold;
    assign pop        = btb_wvalid;
    assign btb_awaddr = fifo_mem[rd_ptr[IDX_W-1:0]].pc;
    assign btb_wdata  = fifo_mem[rd_ptr[IDX_W-1:0]].target;

    assign redirect_valid = (state == REDIRECT);
    assign redirect_pc    = redirect_pc_q;
    assign perf_cf_cnt    = cf_cnt;
    assign perf_mis_cnt   = mis_cnt;

    // Redirect FSM: hold the refetch target until the IFU takes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            redirect_pc_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && mis) begin
                        state         <= REDIRECT;
                        redirect_pc_q <= in_actual_npc;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Queue pointers; draining is independent of the redirect state.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Queue storage; contents are only meaningful behind the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[IDX_W-1:0]].pc     <= in_pc;
            fifo_mem[wr_ptr[IDX_W-1:0]].target <= in_actual_npc;
        end
    end

    // Performance counters, free-running with natural 32-bit wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            cf_cnt  <= '0;
            mis_cnt <= '0;
        end else if (accept) begin
            cf_cnt <= cf_cnt + 32'd1;
            if (mis) mis_cnt <= mis_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_btb_update.sv
// Scoreboard bench for the BTB update path: a transaction-level model predicts
// redirects, training writes and counters; a negedge monitor compares.
module tb_ysyx_23060236_btb_update;

    localparam int DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_pred_npc;
    logic [31:0] in_actual_npc;
    logic        in_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        wr_hold;
    logic        btb_wvalid;
    logic [31:0] btb_awaddr;
    logic [31:0] btb_wdata;
    logic [31:0] perf_cf_cnt;
    logic [31:0] perf_mis_cnt;

    ysyx_23060236_btb_update #(.ADDR_LEN(32), .DATA_LEN(32), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_pred_npc(in_pred_npc), .in_actual_npc(in_actual_npc), .in_taken(in_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .wr_hold(wr_hold),
        .btb_wvalid(btb_wvalid), .btb_awaddr(btb_awaddr), .btb_wdata(btb_wdata),
        .perf_cf_cnt(perf_cf_cnt), .perf_mis_cnt(perf_mis_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
    } wr_t;

    int          checks = 0;
    int          errors = 0;

    // Reference model state
    bit          started = 0;
    bit          m_redir = 0;
    int          m_cnt   = 0;
    logic [31:0] m_cf    = 0;
    logic [31:0] m_mis   = 0;
    logic [31:0] rq[$];
    wr_t         wq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one resolved instruction per accept; mispredict -> redirect,
    // taken mispredict -> training write; queue drains one per unheld cycle.
    always @(posedge clock) begin
        if (reset) begin
            started = 1;
            m_redir = 0;
            m_cnt   = 0;
            m_cf    = 0;
            m_mis   = 0;
            rq.delete();
            wq.delete();
        end else if (started) begin
            bit rdy, acc, drain;
            rdy   = !m_redir && (m_cnt < DEPTH);
            acc   = in_valid && rdy;
            drain = (m_cnt > 0) && !wr_hold;
            if (m_redir && redirect_ready) m_redir = 0;
            if (acc) begin
                m_cf = m_cf + 1;
                if (in_pred_npc != in_actual_npc) begin
                    m_mis   = m_mis + 1;
                    m_redir = 1;
                    rq.push_back(in_actual_npc);
                    if (in_taken) begin
                        wq.push_back('{pc: in_pc, tgt: in_actual_npc});
                        m_cnt++;
                    end
                end
            end
            if (drain) m_cnt--;
        end
    end

    // Monitor: compare DUT outputs against model, pop expected transactions.
    bit          rv_seen = 0;
    logic [31:0] rpc_exp = 0;
    always @(negedge clock) begin
        if (started) begin
            chk("in_ready", 64'(in_ready), 64'(!m_redir && (m_cnt < DEPTH)));
            chk("redirect_valid", 64'(redirect_valid), 64'(m_redir));
            chk("btb_wvalid", 64'(btb_wvalid), 64'((m_cnt > 0) && !wr_hold));
            if (btb_wvalid) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL btb_write_unexpected: got addr %0h expected none", btb_awaddr);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("btb_awaddr", 64'(btb_awaddr), 64'(e.pc));
                    chk("btb_wdata", 64'(btb_wdata), 64'(e.tgt));
                end
            end
            if (redirect_valid) begin
                if (!rv_seen) begin
                    if (rq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL redirect_unexpected: got pc %0h expected none", redirect_pc);
                    end else begin
                        rpc_exp = rq.pop_front();
                    end
                    rv_seen = 1;
                end
                chk("redirect_pc", 64'(redirect_pc), 64'(rpc_exp));
                if (redirect_ready) rv_seen = 0;
            end
            chk("perf_cf_cnt", 64'(perf_cf_cnt), 64'(m_cf));
            chk("perf_mis_cnt", 64'(perf_mis_cnt), 64'(m_mis));
        end
        if (reset) rv_seen = 0;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] pc, input logic [31:0] pred,
                        input logic [31:0] act, input logic tk);
        bit r;
        bit done;
        in_valid = 1; in_pc = pc; in_pred_npc = pred; in_actual_npc = act; in_taken = tk;
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clock);
            r = in_ready;
            cyc();
            if (r) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept expected accept for pc %0h", pc);
        end
        in_valid = 0;
    endtask

    initial begin
        reset = 1; in_valid = 0; in_pc = 0; in_pred_npc = 0; in_actual_npc = 0;
        in_taken = 0; redirect_ready = 1; wr_hold = 0;
        cyc(); cyc();
        reset = 0;
        cyc();

        // Taken mispredict: redirect plus training write
        send(32'h8000_0010, 32'h8000_0014, 32'h8000_0040, 1);
        cyc(); cyc();
        // Correct prediction: no redirect, no write
        send(32'h8000_0020, 32'h8000_0040, 32'h8000_0040, 1);
        cyc();
        // Not-taken predicted taken: redirect only
        send(32'h8000_0014, 32'h8000_0100, 32'h8000_0018, 0);
        cyc(); cyc();

        // Hold drain with three training mispredicts; FIFO fills after two
        wr_hold = 1;
        send(32'h8000_1000, 32'h8000_1004, 32'h8000_2000, 1);
        send(32'h8000_1100, 32'h8000_1104, 32'h8000_2100, 1);
        fork
            send(32'h8000_1200, 32'h8000_1204, 32'h8000_2200, 1);
            begin repeat (4) cyc(); wr_hold = 0; end
        join
        repeat (4) cyc();

        // IFU stalls the redirect for five cycles
        redirect_ready = 0;
        send(32'h8000_3000, 32'h8000_3004, 32'h8000_4000, 1);
        repeat (5) cyc();
        redirect_ready = 1;
        repeat (3) cyc();

        // Reset in the middle of a redirect with two queued writes
        wr_hold = 1;
        send(32'h8000_5000, 32'h8000_5004, 32'h8000_6000, 1);
        cyc();
        redirect_ready = 0;
        send(32'h8000_5100, 32'h8000_5104, 32'h8000_6100, 1);
        cyc();
        reset = 1;
        cyc();
        reset = 0; wr_hold = 0; redirect_ready = 1;
        repeat (3) cyc();

        // Counter wrap
        force dut.cf_cnt = 32'hFFFF_FFFF;
        m_cf = 32'hFFFF_FFFF;
        #1;
        release dut.cf_cnt;
        send(32'h8000_7000, 32'h8000_7004, 32'h8000_7004, 1);
        cyc();
        chk("cf_wrap", 64'(perf_cf_cnt), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            in_valid       = ($urandom_range(0, 3) != 0);
            in_pc          = {$urandom_range(0, 255), 2'b00} | 32'h8000_0000;
            a              = {$urandom_range(0, 255), 2'b00} | 32'h8000_0000;
            in_actual_npc  = a;
            in_pred_npc    = ($urandom_range(0, 1) != 0) ? a : (a + 32'd4);
            in_taken       = $urandom_range(0, 1);
            redirect_ready = ($urandom_range(0, 2) != 0);
            wr_hold        = ($urandom_range(0, 3) == 0);
            cyc();
        end
        in_valid = 0; wr_hold = 0; redirect_ready = 1;
        repeat (6) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
